// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared FSM encoding, GRB width and default WS2812 timing
package neopixel_pkg;

  localparam int GRB_W        = 24;
  localparam int DEF_NUM_LEDS = 64;
  localparam int DEF_T0H_CYC  = 20;
  localparam int DEF_T1H_CYC  = 40;
  localparam int DEF_TBIT_CYC = 63;
  localparam int DEF_TRST_CYC = 2600;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_t;

endpackage

// File: rtl/neopixel_bit_timer.sv
// rtl/neopixel_bit_timer.sv - one WS2812 bit: high for T0H/T1H cycles, low to TBIT_CYC
module neopixel_bit_timer #(
  parameter int T0H_CYC  = 20,
  parameter int T1H_CYC  = 40,
  parameter int TBIT_CYC = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic bit_end
);

  localparam int CW = $clog2(TBIT_CYC);

  logic [CW-1:0] cnt;
  logic          active;
  logic          val;

  // a start on the bit_end cycle restarts immediately, so bits stay back-to-back
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      val    <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      val    <= bit_val;
    end else if (bit_end) begin
      active <= 1'b0;
    end else if (active) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = active && (cnt == CW'(TBIT_CYC - 1));
  assign dout    = active && (cnt < (val ? CW'(T1H_CYC) : CW'(T0H_CYC)));

endmodule

// File: rtl/neopixel_frame_tx.sv
// rtl/neopixel_frame_tx.sv - on/off bitmap to WS2812 frame serializer
// NEOPIXEL_SERPENTINE_EN: odd rows are sent right-to-left for serpentine wiring.
module neopixel_frame_tx
  import neopixel_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H_CYC  = DEF_T0H_CYC,
  parameter int T1H_CYC  = DEF_T1H_CYC,
  parameter int TBIT_CYC = DEF_TBIT_CYC,
  parameter int TRST_CYC = DEF_TRST_CYC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_LEDS-1:0] frame,
  input  logic [GRB_W-1:0]    color,
  input  logic                frame_valid,
  output logic                frame_ready,
  output logic                dout,
  output logic                busy,
  output logic                frame_done
);

  localparam int LW = $clog2(NUM_LEDS + 1);
  localparam int TW = $clog2(TRST_CYC + 1);
  localparam int FW = 1 << LW;

  state_t                state, state_nxt;
  logic [NUM_LEDS-1:0]   frame_q;
  logic [GRB_W-1:0]      color_q;
  logic [LW-1:0]         led_cnt, led_nxt, pix;
  logic [4:0]            bit_cnt, bit_nxt;
  logic [TW-1:0]         lat_cnt, lat_nxt;
  logic                  done_nxt;
  logic                  start;
  logic                  bit_val;
  logic                  bit_end;
  logic [FW-1:0]         frame_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      led_cnt    <= '0;
      bit_cnt    <= '0;
      lat_cnt    <= '0;
      frame_done <= 1'b0;
      frame_q    <= '0;
      color_q    <= '0;
    end else begin
      state      <= state_nxt;
      led_cnt    <= led_nxt;
      bit_cnt    <= bit_nxt;
      lat_cnt    <= lat_nxt;
      frame_done <= done_nxt;
      if (state == IDLE && frame_valid) begin
        frame_q <= frame;
        color_q <= color;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    led_nxt   = led_cnt;
    bit_nxt   = bit_cnt;
    lat_nxt   = lat_cnt;
    done_nxt  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (frame_valid) begin
          state_nxt = SEND;
          led_nxt   = '0;
          bit_nxt   = '0;
          start     = 1'b1;
        end
      end
      SEND: begin
        if (bit_end) begin
          if (bit_cnt == 5'd23) begin
            bit_nxt = '0;
            led_nxt = led_cnt + 1'b1;
            if (led_cnt == LW'(NUM_LEDS - 1)) begin
              state_nxt = LATCH;
              lat_nxt   = '0;
            end else begin
              start = 1'b1;
            end
          end else begin
            bit_nxt = bit_cnt + 1'b1;
            start   = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_cnt == TW'(TRST_CYC - 1)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          lat_nxt   = '0;
          led_nxt   = '0;
        end else begin
          lat_nxt = lat_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first bit is launched on the transfer edge, before frame_q/color_q hold it.
  // frame_ext is zero-padded so the LED index never addresses past the bitmap.
  always_comb begin
    frame_ext                 = '0;
    frame_ext[NUM_LEDS-1:0]   = (state == IDLE) ? frame : frame_q;
    pix                       = led_nxt;
`ifdef NEOPIXEL_SERPENTINE_EN
    if (led_nxt[3]) pix = led_nxt ^ LW'(7);
`endif
    bit_val = frame_ext[pix] &
              ((state == IDLE) ? color[5'd23 - bit_nxt] : color_q[5'd23 - bit_nxt]);
  end

  neopixel_bit_timer #(
    .T0H_CYC  (T0H_CYC),
    .T1H_CYC  (T1H_CYC),
    .TBIT_CYC (TBIT_CYC)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bit_val (bit_val),
    .dout    (dout),
    .bit_end (bit_end)
  );

  assign frame_ready = (state == IDLE);
  assign busy        = (state != IDLE);

endmodule

// File: doc/neopixel_frame_tx.md
NEOPIXEL_FRAME_TX -- requirements
Module: neopixel_frame_tx

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 64, LEDs per frame (8x8 matrix).
REQ-002 SHALL have parameter T0H_CYC, default 20, high time of a 0 bit in clk cycles.
REQ-003 SHALL have parameter T1H_CYC, default 40, high time of a 1 bit in clk cycles.
REQ-004 SHALL have parameter TBIT_CYC, default 63, total bit period in clk cycles.
REQ-005 SHALL have parameter TRST_CYC, default 2600, latch low time in clk cycles.
REQ-006 SHALL have port clk, input, 1, sole clock; one clock domain; reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port frame, input, NUM_LEDS, on/off bitmap; bit i is matrix pixel i, row = i/8, col = i%8.
REQ-009 SHALL have port color, input, 24, GRB colour for lit pixels; MSB sent first.
REQ-010 SHALL have port frame_valid, input, 1, frame offered.
REQ-011 SHALL have port frame_ready, output, 1, block accepts a frame.
REQ-012 SHALL have port dout, output, 1, WS2812 serial data line.
REQ-013 SHALL have port busy, output, 1, frame transmission or latch in progress.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse at end of latch.

Function
REQ-015 SHALL use FSM states IDLE, SEND, LATCH.
REQ-016 SHALL assert frame_ready only in IDLE; the transfer occurs when frame_valid && frame_ready are high on the same rising edge.
REQ-017 SHALL register frame and color on transfer; input changes during SEND/LATCH SHALL have no effect.
REQ-018 SHALL move IDLE->SEND on transfer, with the first bit high phase beginning the next cycle.
REQ-019 SHALL send each LED as 24 bits: color if the pixel is set, 24'h000000 otherwise.
REQ-020 SHALL send LEDs in order 0..NUM_LEDS-1.
REQ-021 SHALL drive dout high for T0H_CYC (bit 0) or T1H_CYC (bit 1) cycles, then low for the remainder of TBIT_CYC, per bit.
REQ-022 SHALL send bits back-to-back with no gap between bits or LEDs.
REQ-023 SHALL move SEND->LATCH after bit 0 of LED NUM_LEDS-1 completes; dout SHALL be held 0 for TRST_CYC cycles.
REQ-024 SHALL move LATCH->IDLE at the end of the latch period, pulse frame_done for exactly 1 cycle on that edge, and raise frame_ready the same cycle.
REQ-025 SHALL size the bit counter at 5 bits (wrapping 23->0) and the LED counter at clog2(NUM_LEDS+1) bits, and SHALL use a timer wide enough for TRST_CYC.
REQ-026 SHALL hold busy = 1 in SEND and LATCH, and 0 in IDLE.
REQ-027 SHALL make total frame time NUM_LEDS*24*TBIT_CYC + TRST_CYC cycles, from the first dout high edge to frame_done.

Reset
REQ-028 SHALL, on rst high at a clk edge, enter IDLE with dout=0, busy=0, frame_done=0, frame_ready=1, and all counters 0.
REQ-029 SHALL, if rst is asserted mid-SEND, abort immediately: dout=0 next cycle, no frame_done; the next frame SHALL start only after a fresh transfer.
REQ-030 SHALL give rst priority over a simultaneous frame_valid.

Configuration
REQ-031 SHALL, with macro NEOPIXEL_SERPENTINE_EN defined, send the LED at odd row r, col c using frame bit r*8+(7-c), to match serpentine matrix wiring; even rows are unchanged.
REQ-032 SHALL, without NEOPIXEL_SERPENTINE_EN, map LED k to frame bit k for all rows.

Structure
REQ-033 SHALL place the FSM state enum, default timing constants, and the 24-bit GRB width in shared package neopixel_pkg.
REQ-034 SHALL use one sub-module, neopixel_bit_timer, which takes a bit value and a start strobe, produces the high/low waveform, and signals bit_end.

Verification
REQ-035 SHALL verify: frame=64'h1, color=24'hFF0000, one transfer -> LED0 bits 1x8 then 0x16; LEDs 1..63 all 0-bits; frame_done 1 pulse.
REQ-036 SHALL verify: 0-bit and 1-bit widths measured on dout -> exactly 20/43 and 40/23 high/low cycles, period 63.
REQ-037 SHALL verify: frame_valid held high continuously -> frames separated by 2600 low cycles; frame_ready low while busy.
REQ-038 SHALL verify: rst asserted at LED 10, bit 5 -> dout=0 and busy=0 next cycle; no frame_done; next frame restarts at LED0.
REQ-039 SHALL verify: frame bits changed mid-SEND -> transmitted data equals the latched frame.
REQ-040 SHALL verify: NEOPIXEL_SERPENTINE_EN defined, frame bit 8 set -> LED 15 lit, LED 8 dark; undefined -> LED 8 lit.
